gps_display_formatter: RTL and testbench
========================================

# gps_display_formatter

Downstream stage of the NMEA parser. It captures the parsed fix fields (lat_deg, lat_min, lon_deg, lon_min, valid_fix) and converts them to two 16-character ASCII lines in a double-buffered 32-byte character store. The LCD1602 controller reads that store by character index. Conversion is sequential through one shared binary-to-BCD unit, and the front buffer swaps atomically so the LCD never shows a half-updated frame.

## Interface
- DATA_BITS, 8, character and field width
- NUM_CHARS, 32, characters in the store (2 lines × 16)
- LAT_MAX, 90, largest valid latitude degrees
- LON_MAX, 180, largest valid longitude degrees
- MIN_MAX, 59, largest valid minutes value

Ports:
- clk_50MHz  in  1  system clock
- reset  in  1  asynchronous, active-low
- lat_deg  in  8  latitude degrees, binary
- lat_min  in  8  latitude minutes, binary
- lon_deg  in  8  longitude degrees, binary
- lon_min  in  8  longitude minutes, binary
- valid_fix  in  1  parser fix-valid level
- rd_addr  in  5  character index; 0–15 is line 0, 16–31 is line 1
- rd_data  out  8  ASCII character of the front buffer
- busy  out  1  conversion in progress
- frame_ready  out  1  one-cycle pulse when a new frame is swapped to the front buffer

## Operation
- **Line 0 template:** "LAT ddd" + 0xDF + "mm'" + 5 spaces.
- **Line 1 template:** "LON ddd" + 0xDF + "mm'" + 5 spaces.
- **Field positions, line 0:** degree digits at addresses 4–6, minute digits at 8–9.
- **Field positions, line 1:** degree digits at 20–22, minute digits at 24–25.
- **Trigger:** sampled only in IDLE.
  - Fires when the inputs differ from the shadow snapshot {fields, valid_fix} taken at the last trigger.
  - Fires once after reset, with the shadow initialised to a value that cannot match the inputs.
  - Changes during busy are not lost: they are compared again on return to IDLE.
- **FSM states:** IDLE → CAPTURE → (LOAD → SHIFT×8 → WRITE×n) per field, in order lat_deg, lat_min, lon_deg, lon_min → SWAP → IDLE.
  - n = 3 for degree fields, 2 for minute fields.
- **Conversion:** double-dabble of the 8-bit snapshot into 3 BCD digits. Each written character is 0x30 + digit.
  - Minute fields write only the tens and units digits.
- **Range rule:**
  - lat_deg > LAT_MAX → "???"
  - lon_deg > LON_MAX → "???"
  - any minutes field > MIN_MAX → "??"
- **No fix:** if the snapshot valid_fix = 0, every digit position is written '-' (0x2D). The sequence and its timing are unchanged.
- **Write target:** WRITE cycles store into the back buffer only.
- **SWAP:** copies the back buffer into the front buffer in one cycle and pulses frame_ready.
- **Reset values:**
  - both buffers hold the template with '-' in every digit position
  - rd_data = 0x00
  - busy = 0
  - frame_ready = 0
  - FSM in IDLE
- **Reset mid-conversion:** aborts the conversion, the front buffer returns to the reset template, and no frame_ready pulse is issued.

## Timing
- Trigger sampled in IDLE at cycle 0; CAPTURE registers the snapshot.
- Field windows:
  - lat_deg: cycles 1–12
  - lat_min: cycles 13–23
  - lon_deg: cycles 24–35
  - lon_min: cycles 36–46
- SWAP occurs in cycle 47. The new front buffer and frame_ready are visible in cycle 48, exactly 48 cycles after the trigger.
- busy is high from cycle 1 through cycle 47 inclusive.
- After SWAP, the FSM is in IDLE at cycle 48 and can retrigger at the earliest in cycle 48.
- rd_data is registered: it is the front-buffer character at the rd_addr presented in the previous cycle.
  - A read in the SWAP cycle returns the old frame.
  - The following read returns the new frame.
- No tearing: the front buffer changes only in SWAP.

## Structure
- **Shared package/include `gps_fmt_pkg`:**
  - state encoding
  - character constants: space, '-', '?', 0xDF, apostrophe, 0x30 digit base
  - field address offsets (4, 8, 20, 24)
  - template initialiser function
- **Sub-module `bin2bcd8`:**
  - 8-bit input, three 4-bit BCD digit outputs
  - start/done handshake
  - 8 shift cycles, one per SHIFT state
- **Top:** FSM, snapshot/shadow registers, back and front 32×8 register arrays, read register.

## Test plan
- Reset, then valid_fix = 0 → frame_ready at cycle 48; line 0 reads "LAT ---" + 0xDF + "--'".
- lat 4°37', lon 74°05', valid = 1 → line 0 "LAT 004" + 0xDF + "37'", line 1 "LON 074" + 0xDF + "05'"; busy high exactly 47 cycles.
- lat_deg = 95, lon_min = 60 → addresses 4–6 read "???", addresses 24–25 read "??"; other fields are correct.
- Change lon_deg during busy → the current frame completes with the old value; a second frame_ready follows 48 cycles after the return to IDLE and shows the new value.
- Continuous reads during SWAP → no mixed-frame character sequence; rd_data lags rd_addr by 1 cycle.
- Assert reset at cycle 20 of a conversion → outputs return to reset values, no frame_ready pulse, and after release the front buffer holds the template.

Source files
------------

// File: rtl/gps_fmt_pkg.sv
// Shared definitions for the GPS display formatter: FSM encoding, character
// constants, field addresses and the power-on display template.
package gps_fmt_pkg;

    localparam int CHAR_W      = 8;
    localparam int STORE_CHARS = 32;
    localparam int LINE_CHARS  = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_SWAP    = 3'd5;

    localparam logic [1:0] FLD_LAT_DEG = 2'd0;
    localparam logic [1:0] FLD_LAT_MIN = 2'd1;
    localparam logic [1:0] FLD_LON_DEG = 2'd2;
    localparam logic [1:0] FLD_LON_MIN = 2'd3;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DASH   = 8'h2D;
    localparam logic [7:0] CH_QMARK  = 8'h3F;
    localparam logic [7:0] CH_DEG    = 8'hDF;
    localparam logic [7:0] CH_APOS   = 8'h27;
    localparam logic [7:0] CH_DIGIT0 = 8'h30;

    localparam logic [4:0] LAT_DEG_ADDR = 5'd4;
    localparam logic [4:0] LAT_MIN_ADDR = 5'd8;
    localparam logic [4:0] LON_DEG_ADDR = 5'd20;
    localparam logic [4:0] LON_MIN_ADDR = 5'd24;

    typedef logic [STORE_CHARS-1:0][CHAR_W-1:0] char_store_t;

    typedef struct packed {
        logic [7:0] lat_deg;
        logic [7:0] lat_min;
        logic [7:0] lon_deg;
        logic [7:0] lon_min;
        logic       valid_fix;
    } fix_t;

    // Both lines read "LA T --- o --'" style with '-' in every digit slot.
    function automatic char_store_t template_init();
        char_store_t s;
        for (int i = 0; i < STORE_CHARS; i++) begin
            int col;
            bit lon;
            col = i % LINE_CHARS;
            lon = (i >= LINE_CHARS);
            case (col)
                0:       s[i] = 8'h4C;
                1:       s[i] = lon ? 8'h4F : 8'h41;
                2:       s[i] = lon ? 8'h4E : 8'h54;
                3:       s[i] = CH_SPACE;
                4, 5, 6: s[i] = CH_DASH;
                7:       s[i] = CH_DEG;
                8, 9:    s[i] = CH_DASH;
                10:      s[i] = CH_APOS;
                default: s[i] = CH_SPACE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/gps_display_formatter_bin2bcd8.sv
// Sequential double-dabble: start loads the byte, then eight shift cycles
// produce three BCD digits; done marks the cycle of the final shift.
module bin2bcd8 (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin_in,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    // {hundreds, tens, ones, remaining binary}
    logic [19:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] step;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        step  = sr_q;
        if (start) begin
            sr_d  = {12'd0, bin_in};
            cnt_d = 4'd8;
        end else if (cnt_q != 4'd0) begin
            if (step[19:16] >= 4'd5) step[19:16] = step[19:16] + 4'd3;
            if (step[15:12] >= 4'd5) step[15:12] = step[15:12] + 4'd3;
            if (step[11:8]  >= 4'd5) step[11:8]  = step[11:8]  + 4'd3;
            sr_d  = {step[18:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign hundreds = sr_q[19:16];
    assign tens     = sr_q[15:12];
    assign ones     = sr_q[11:8];
    assign done     = (cnt_q == 4'd1);

endmodule

// File: rtl/gps_display_formatter.sv
// Converts a captured GPS fix into two 16-char ASCII lines held in a
// double-buffered store; the LCD reads the front buffer, which only changes in SWAP.
module gps_display_formatter
    import gps_fmt_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NUM_CHARS = 32,
    parameter int LAT_MAX   = 90,
    parameter int LON_MAX   = 180,
    parameter int MIN_MAX   = 59
) (
    input  logic                         clk_50MHz,
    input  logic                         reset,
    input  logic [DATA_BITS-1:0]         lat_deg,
    input  logic [DATA_BITS-1:0]         lat_min,
    input  logic [DATA_BITS-1:0]         lon_deg,
    input  logic [DATA_BITS-1:0]         lon_min,
    input  logic                         valid_fix,
    input  logic [$clog2(NUM_CHARS)-1:0] rd_addr,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic                         busy,
    output logic                         frame_ready
);

    localparam logic [7:0] LAT_LIM = 8'(LAT_MAX);
    localparam logic [7:0] LON_LIM = 8'(LON_MAX);
    localparam logic [7:0] MIN_LIM = 8'(MIN_MAX);

    logic [2:0]  state_q, state_d;
    logic [1:0]  fld_q, fld_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    fix_t        snap_q, snap_d;
    logic        primed_q, primed_d;
    char_store_t back_q, back_d;
    char_store_t front_q, front_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        frame_ready_q, frame_ready_d;

    fix_t        fix_in;
    logic [7:0]  field_val, field_lim;
    logic [4:0]  field_base, wr_addr;
    logic        is_deg;
    logic [1:0]  digit_sel, last_idx;
    logic [3:0]  digit;
    logic [7:0]  wr_char;
    logic        bcd_start, bcd_done;
    logic [3:0]  bcd_h, bcd_t, bcd_o;

    always_comb begin
        fix_in.lat_deg   = lat_deg;
        fix_in.lat_min   = lat_min;
        fix_in.lon_deg   = lon_deg;
        fix_in.lon_min   = lon_min;
        fix_in.valid_fix = valid_fix;
    end

    always_comb begin
        field_val  = snap_q.lat_deg;
        field_lim  = LAT_LIM;
        field_base = LAT_DEG_ADDR;
        unique case (fld_q)
            FLD_LAT_DEG: begin field_val = snap_q.lat_deg; field_lim = LAT_LIM; field_base = LAT_DEG_ADDR; end
            FLD_LAT_MIN: begin field_val = snap_q.lat_min; field_lim = MIN_LIM; field_base = LAT_MIN_ADDR; end
            FLD_LON_DEG: begin field_val = snap_q.lon_deg; field_lim = LON_LIM; field_base = LON_DEG_ADDR; end
            FLD_LON_MIN: begin field_val = snap_q.lon_min; field_lim = MIN_LIM; field_base = LON_MIN_ADDR; end
        endcase
    end

    // Minute fields skip the hundreds digit, so their first write is the tens.
    assign is_deg    = ~fld_q[0];
    assign last_idx  = is_deg ? 2'd2 : 2'd1;
    assign digit_sel = is_deg ? wr_idx_q : wr_idx_q + 2'd1;
    assign wr_addr   = field_base + {3'd0, wr_idx_q};

    always_comb begin
        digit = bcd_o;
        case (digit_sel)
            2'd0:    digit = bcd_h;
            2'd1:    digit = bcd_t;
            default: digit = bcd_o;
        endcase
        if (!snap_q.valid_fix)         wr_char = CH_DASH;
        else if (field_val > field_lim) wr_char = CH_QMARK;
        else                            wr_char = CH_DIGIT0 + {4'd0, digit};
    end

    always_comb begin
        state_d       = state_q;
        fld_d         = fld_q;
        wr_idx_d      = wr_idx_q;
        snap_d        = snap_q;
        primed_d      = primed_q;
        back_d        = back_q;
        front_d       = front_q;
        frame_ready_d = 1'b0;
        bcd_start     = 1'b0;
        rd_data_d     = front_q[rd_addr];
        case (state_q)
            ST_IDLE: begin
                if (!primed_q || (fix_in != snap_q)) begin
                    snap_d   = fix_in;
                    primed_d = 1'b1;
                    state_d  = ST_CAPTURE;
                end
            end
            // The snapshot is already registered here, so CAPTURE doubles as
            // the lat_deg load and keeps the frame at 48 cycles.
            ST_CAPTURE, ST_LOAD: begin
                bcd_start = 1'b1;
                wr_idx_d  = 2'd0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bcd_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                back_d[wr_addr] = wr_char;
                if (wr_idx_q == last_idx) begin
                    wr_idx_d = 2'd0;
                    if (fld_q == FLD_LON_MIN) begin
                        state_d = ST_SWAP;
                    end else begin
                        fld_d   = fld_q + 2'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    wr_idx_d = wr_idx_q + 2'd1;
                end
            end
            ST_SWAP: begin
                front_d       = back_q;
                frame_ready_d = 1'b1;
                fld_d         = FLD_LAT_DEG;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fld_q         <= FLD_LAT_DEG;
            wr_idx_q      <= '0;
            snap_q        <= '0;
            primed_q      <= 1'b0;
            back_q        <= template_init();
            front_q       <= template_init();
            rd_data_q     <= '0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fld_q         <= fld_d;
            wr_idx_q      <= wr_idx_d;
            snap_q        <= snap_d;
            primed_q      <= primed_d;
            back_q        <= back_d;
            front_q       <= front_d;
            rd_data_q     <= rd_data_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    bin2bcd8 u_bcd (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .start     (bcd_start),
        .bin_in    (field_val),
        .hundreds  (bcd_h),
        .tens      (bcd_t),
        .ones      (bcd_o),
        .done      (bcd_done)
    );

    assign rd_data     = rd_data_q;
    assign frame_ready = frame_ready_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gps_display_formatter.sv
// Directed bench for gps_display_formatter: frame timing, formatting, range
// and no-fix cases, update during busy, read lag across SWAP, mid-frame reset.
module tb_gps_display_formatter;

    logic       clk_50MHz = 1'b0;
    logic       reset;
    logic [7:0] lat_deg, lat_min, lon_deg, lon_min;
    logic       valid_fix;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, frame_ready;

    int nvec = 0;
    int nerr = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    gps_display_formatter dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .lat_deg     (lat_deg),
        .lat_min     (lat_min),
        .lon_deg     (lon_deg),
        .lon_min     (lon_min),
        .valid_fix   (valid_fix),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .frame_ready (frame_ready)
    );

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_line(input int base, output logic [127:0] line);
        line = '0;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 5'(base + i);
            tick();
            line[127 - 8*i -: 8] = rd_data;
        end
    endtask

    // Cycles counted from the edge that samples the trigger; bounded.
    task automatic wait_frame(input int n0, output int n, output int nb);
        n  = n0;
        nb = 0;
        do begin
            tick();
            n++;
            if (busy) nb++;
        end while (!frame_ready && n < 200);
    endtask

    initial begin
        logic [127:0] ln;
        int n, nb;
        logic [4:0] prev_addr;
        logic [7:0] exp_ch;

        reset = 1'b0; rd_addr = '0;
        lat_deg = 8'd0; lat_min = 8'd0; lon_deg = 8'd0; lon_min = 8'd0; valid_fix = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 128'({busy, frame_ready, rd_data}), 128'(10'h000));

        // 1: first frame after reset, no fix
        reset = 1'b1;
        wait_frame(0, n, nb);
        chk("nofix_latency", 128'(n), 128'(48));
        chk("nofix_busy_cycles", 128'(nb), 128'(47));
        read_line(0, ln);
        chk("nofix_line0", ln, {"LAT ---", 8'hDF, "--'     "});
        read_line(16, ln);
        chk("nofix_line1", ln, {"LON ---", 8'hDF, "--'     "});

        // 2: 4 deg 37 min, 74 deg 05 min
        lat_deg = 8'd4; lat_min = 8'd37; lon_deg = 8'd74; lon_min = 8'd5; valid_fix = 1'b1;
        wait_frame(0, n, nb);
        chk("fix_latency", 128'(n), 128'(48));
        chk("fix_busy_cycles", 128'(nb), 128'(47));
        tick();
        chk("fix_pulse_one_cycle", 128'({busy, frame_ready}), 128'(2'b00));
        read_line(0, ln);
        chk("fix_line0", ln, {"LAT 004", 8'hDF, "37'     "});
        read_line(16, ln);
        chk("fix_line1", ln, {"LON 074", 8'hDF, "05'     "});

        // 3: out of range lat_deg and lon_min; 180 is the last legal longitude
        lat_deg = 8'd95; lat_min = 8'd12; lon_deg = 8'd180; lon_min = 8'd60;
        wait_frame(0, n, nb);
        chk("range_a_latency", 128'(n), 128'(48));
        read_line(0, ln);
        chk("range_a_line0", ln, {"LAT ???", 8'hDF, "12'     "});
        read_line(16, ln);
        chk("range_a_line1", ln, {"LON 180", 8'hDF, "??'     "});

        lat_deg = 8'd90; lat_min = 8'd59; lon_deg = 8'd181; lon_min = 8'd0;
        wait_frame(0, n, nb);
        chk("range_b_latency", 128'(n), 128'(48));
        read_line(0, ln);
        chk("range_b_line0", ln, {"LAT 090", 8'hDF, "59'     "});
        read_line(16, ln);
        chk("range_b_line1", ln, {"LON ???", 8'hDF, "00'     "});

        // 4: lon_deg changes mid-frame; old value completes, new one follows
        lon_deg = 8'd10;
        repeat (10) tick();
        lon_deg = 8'd20;
        wait_frame(10, n, nb);
        chk("busy_change_first_latency", 128'(n), 128'(48));
        read_line(16, ln);
        chk("busy_change_first_line1", ln, {"LON 010", 8'hDF, "00'     "});
        wait_frame(16, n, nb);
        chk("busy_change_second_latency", 128'(n), 128'(48));
        read_line(16, ln);
        chk("busy_change_second_line1", ln, {"LON 020", 8'hDF, "00'     "});

        // 5: reads every cycle across SWAP, alternating two addresses
        lon_deg = 8'd30;
        rd_addr = 5'd21;
        for (int k = 1; k <= 52; k++) begin
            prev_addr = rd_addr;
            tick();
            if (prev_addr == 5'd20) exp_ch = 8'h30;
            else                    exp_ch = (k >= 49) ? 8'h33 : 8'h32;
            chk($sformatf("swap_read_k%0d", k), 128'(rd_data), 128'(exp_ch));
            chk($sformatf("swap_pulse_k%0d", k), 128'(frame_ready), 128'(k == 48));
            rd_addr = (k % 4 == 1) ? 5'd20 : 5'd21;
        end

        // 6: reset 20 cycles into a frame
        lat_deg = 8'd1;
        repeat (20) tick();
        chk("midrst_busy_before", 128'(busy), 128'(1));
        reset = 1'b0;
        #1;
        chk("midrst_outputs", 128'({busy, frame_ready, rd_data}), 128'(10'h000));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_pulse", 128'({busy, frame_ready}), 128'(2'b00));
        end
        reset = 1'b1;
        read_line(0, ln);
        chk("midrst_line0_template", ln, {"LAT ---", 8'hDF, "--'     "});
        read_line(16, ln);
        chk("midrst_line1_template", ln, {"LON ---", 8'hDF, "--'     "});
        wait_frame(32, n, nb);
        chk("midrst_refire_latency", 128'(n), 128'(48));
        read_line(0, ln);
        chk("midrst_refire_line0", ln, {"LAT 001", 8'hDF, "59'     "});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
